motoro3_step_sequencer: RTL and testbench
=========================================

Name: motoro3_step_sequencer

Overview:
- Timing master that sits directly upstream of the PWM generator.
- Produces the per-PWM-period counter `m3cnt` and its First/Last strobes.
- Produces the 16-step electrical step index `sgStep` and the per-step position length `plLen`.
- Produces the `pwmActive1` qualifier.
- Every output is registered and changes on the falling edge of `clk`, so all PWM-generator inputs are stable for a full period.

Parameters:
- CNT_W, 25, width of `m3cnt` and of the period length.
- MIN_PERIOD, 4, smallest accepted period length; smaller requests are clamped to this.

Ports:
- clk  in  1  10 MHz system clock; all state updates on the falling edge.
- nRst  in  1  reset, asynchronous, active-low.
- m3r_enable  in  1  run request from the register file.
- m3r_periodLen  in  CNT_W  PWM period length in clocks.
- m3r_stepSplitMax  in  2  number of periods per step, minus 1 (0..3 means 1..4 periods).
- m3r_amplitude  in  8  scale for `plLen`.
- m3cnt  out  CNT_W  position inside the current period, 0..P-1.
- m3cntFirst1  out  1  high while m3cnt==0.
- m3cntFirst2  out  1  high while m3cnt==1.
- m3cntLast2  out  1  high while m3cnt==P-2.
- m3cntLast1  out  1  high while m3cnt==P-1.
- sgStep  out  4  current step, 0..15.
- plLen  out  16  position length for the current step.
- pwmActive1  out  1  run qualifier, aligned to a period boundary.
- cycleDone  out  1  one-period pulse marking a wrap of sgStep from 15 to 0.

Behaviour:
- Reset (asynchronous, or assertion at any time, including mid-period), all outputs and state cleared:
  - m3cnt=0, all four strobes=0, sgStep=0, plLen=0, pwmActive1=0, cycleDone=0.
  - Split counter=0.
  - Latched period P=MIN_PERIOD.
- Period counter:
  - m3cnt increments by 1 per clock.
  - At m3cnt==P-1 the next value is 0.
  - The counter runs regardless of enable.
- Strobes:
  - Registered, decoded from the next count value.
  - They are therefore exactly aligned with m3cnt.
  - Exception: the cycle released from reset has m3cnt=0 with First1=0. The first First1 is at the first wrap.
  - Order inside a period: First1, First2, ..., Last2, Last1. P=MIN_PERIOD=4 gives four distinct strobes.
- Boundary edge: the falling edge that samples m3cnt==P-1. All of the following happen on that same edge, never mid-period:
  - P <= max(m3r_periodLen, MIN_PERIOD). A mid-period change of m3r_periodLen has no effect until this edge.
  - pwmActive1 <= m3r_enable.
  - Split counter advances:
    - If split==m3r_stepSplitMax (live value): split<=0 and the step advances.
    - Otherwise split<=split+1 and sgStep holds.
    - If m3r_stepSplitMax is lowered below the current split value: treat the split as expired, advance, and clear the split counter.
  - Step advance: sgStep <= sgStep+1, modulo 16 (15 wraps to 0).
  - cycleDone <= 1 when that wrap occurs. It clears at the next boundary edge.
  - plLen <= (STEP_TAB[nextStep] * m3r_amplitude) >> 8, computed as unsigned 14x8 to 22 bits, keeping bits [21:8].
  - plLen is forced to 0 when the new pwmActive1 is 0.
  - With amplitude 255, the maximum plLen is 7968; no saturation is needed.
- Disabled operation:
  - While pwmActive1==0, sgStep and the split counter hold at their values.
  - Enable resumes from the held step.
  - Clearing enable mid-period takes effect at the next boundary edge.
- Latency and hold:
  - plLen and sgStep are valid one full period before they are consumed at the next First1 ... Last1.
  - Both are held constant for the whole period.

Decomposition:
- Package motoro3_pkg holds:
  - STEP_TAB[0..15], unsigned 14-bit values: 0, 1561, 3061, 4445, 5657, 6651, 7391, 7846, 8000, 7846, 7391, 6651, 5657, 4445, 3061, 1561.
  - MIN_PERIOD, CNT_W.
  - The sgStep width (4).
- One sub-module: motoro3_pl_scaler.
  - Combinational table lookup plus multiply-shift.
  - Inputs: step and amplitude. Output: the 16-bit product.
  - The top level registers its result.

Test Plan:
1. Reset, enable=1, P=10, split=0, amp=255 → First1 at m3cnt 0, First2 at 1, Last2 at 8, Last1 at 9. sgStep increments every 10 clocks. plLen sequence: 0, 1554, 3049, … (STEP_TAB*255>>8).
2. split=2, P=6 → sgStep changes every 18 clocks. cycleDone high for exactly one 6-clock period after 15→0.
3. m3r_periodLen changed 10→5 at m3cnt==3 → the current period still ends at 9; the next period is 0..4. Request 2 → P=4 with four distinct strobes.
4. Enable cleared at m3cnt==4 of step 7 → pwmActive1 drops and plLen becomes 0 at the next boundary. sgStep holds 7. Re-enable resumes with step 8 and plLen=STEP_TAB[8]*amp>>8.
5. amp=128 at step 8 → plLen=4000. amp=0 → plLen=0 while pwmActive1=1.
6. nRst pulsed at m3cnt==7, sgStep=12 → all outputs cleared immediately. First1 stays 0 until the first wrap after release.

Source files
------------

// File: rtl/motoro3_pkg.sv
// Shared constants and the sine-shaped step table for the motoro3 step sequencer.
package motoro3_pkg;

  localparam int CNT_W      = 25;
  localparam int MIN_PERIOD = 4;
  localparam int STEP_W     = 4;
  localparam int TAB_W      = 14;
  localparam int AMP_W      = 8;
  localparam int PL_W       = 16;

  typedef logic [STEP_W-1:0] step_t;

  // Unsigned 14-bit position length for each of the 16 electrical steps.
  function automatic logic [TAB_W-1:0] step_tab(input step_t s);
    case (s)
      4'd0:    step_tab = 14'd0;
      4'd1:    step_tab = 14'd1561;
      4'd2:    step_tab = 14'd3061;
      4'd3:    step_tab = 14'd4445;
      4'd4:    step_tab = 14'd5657;
      4'd5:    step_tab = 14'd6651;
      4'd6:    step_tab = 14'd7391;
      4'd7:    step_tab = 14'd7846;
      4'd8:    step_tab = 14'd8000;
      4'd9:    step_tab = 14'd7846;
      4'd10:   step_tab = 14'd7391;
      4'd11:   step_tab = 14'd6651;
      4'd12:   step_tab = 14'd5657;
      4'd13:   step_tab = 14'd4445;
      4'd14:   step_tab = 14'd3061;
      default: step_tab = 14'd1561;
    endcase
  endfunction

endpackage

// File: rtl/motoro3_step_sequencer_if.sv
// Register-file requests into the sequencer and timing outputs towards the PWM generator.
interface motoro3_step_sequencer_if #(
  parameter int CNT_W = motoro3_pkg::CNT_W
);
  logic             m3r_enable;
  logic [CNT_W-1:0] m3r_periodLen;
  logic [1:0]       m3r_stepSplitMax;
  logic [7:0]       m3r_amplitude;

  logic [CNT_W-1:0] m3cnt;
  logic             m3cntFirst1;
  logic             m3cntFirst2;
  logic             m3cntLast2;
  logic             m3cntLast1;
  logic [3:0]       sgStep;
  logic [15:0]      plLen;
  logic             pwmActive1;
  logic             cycleDone;

  // Register file side: issues run requests, observes the timing outputs.
  modport master (
    output m3r_enable, m3r_periodLen, m3r_stepSplitMax, m3r_amplitude,
    input  m3cnt, m3cntFirst1, m3cntFirst2, m3cntLast2, m3cntLast1,
           sgStep, plLen, pwmActive1, cycleDone
  );

  // Sequencer side.
  modport slave (
    input  m3r_enable, m3r_periodLen, m3r_stepSplitMax, m3r_amplitude,
    output m3cnt, m3cntFirst1, m3cntFirst2, m3cntLast2, m3cntLast1,
           sgStep, plLen, pwmActive1, cycleDone
  );
endinterface

// File: rtl/motoro3_pl_scaler.sv
// Combinational step-table lookup scaled by amplitude: (STEP_TAB[step] * amp) >> 8.
module motoro3_pl_scaler
  import motoro3_pkg::*;
(
  input  step_t       step,
  input  logic [7:0]  amplitude,
  output logic [15:0] pl_len
);

  logic [21:0] prod;

  // 14x8 unsigned product; the top 14 bits are the scaled length (max 7968, never saturates).
  always_comb begin
    prod   = {8'd0, step_tab(step)} * {14'd0, amplitude};
    pl_len = {2'b00, prod[21:8]};
  end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// Period counter, strobes, electrical step index and position length for the PWM generator.
// All state changes on the falling clock edge so PWM inputs are stable for a full period.
module motoro3_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int CNT_W      = motoro3_pkg::CNT_W,
  parameter int MIN_PERIOD = motoro3_pkg::MIN_PERIOD
) (
  input  logic                    clk,
  input  logic                    nRst,
  motoro3_step_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] req_period;
  logic             first1_q, first1_d, first2_q, first2_d;
  logic             last2_q, last2_d, last1_q, last1_d;
  step_t            step_q, step_d;
  logic [1:0]       split_q, split_d;
  logic [15:0]      pl_len_q, pl_len_d, pl_scaled;
  logic             active_q, active_d;
  logic             cycle_done_q, cycle_done_d;
  logic             last_cnt, advance;

  // Boundary detection and the step the next period will use (feeds the scaler).
  always_comb begin
    last_cnt   = (cnt_q == period_q - CNT_W'(1));
    req_period = (bus.m3r_periodLen < MIN_P) ? MIN_P : bus.m3r_periodLen;
    // A split value above a lowered maximum counts as expired.
    advance    = last_cnt && bus.m3r_enable && (split_q >= bus.m3r_stepSplitMax);
    step_d     = advance ? step_q + 4'd1 : step_q;
  end

  motoro3_pl_scaler u_scaler (
    .step      (step_d),
    .amplitude (bus.m3r_amplitude),
    .pl_len    (pl_scaled)
  );

  // Next-state: counter always runs; everything else only moves on the boundary edge.
  always_comb begin
    cnt_d        = last_cnt ? '0 : cnt_q + CNT_W'(1);
    period_d     = last_cnt ? req_period : period_q;
    active_d     = last_cnt ? bus.m3r_enable : active_q;
    split_d      = split_q;
    cycle_done_d = cycle_done_q;
    pl_len_d     = pl_len_q;
    if (last_cnt) begin
      cycle_done_d = advance && (step_q == 4'hF);
      pl_len_d     = bus.m3r_enable ? pl_scaled : 16'd0;
      if (bus.m3r_enable) begin
        split_d = advance ? 2'd0 : split_q + 2'd1;
      end
    end
    // Strobes are decoded from the next count against the period that count belongs to.
    first1_d = (cnt_d == '0);
    first2_d = (cnt_d == CNT_W'(1));
    last2_d  = (cnt_d == period_d - CNT_W'(2));
    last1_d  = (cnt_d == period_d - CNT_W'(1));
  end

  // State registers on the falling edge with asynchronous active-low clear.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q        <= '0;
      period_q     <= MIN_P;
      first1_q     <= 1'b0;
      first2_q     <= 1'b0;
      last2_q      <= 1'b0;
      last1_q      <= 1'b0;
      step_q       <= '0;
      split_q      <= '0;
      pl_len_q     <= '0;
      active_q     <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      first1_q     <= first1_d;
      first2_q     <= first2_d;
      last2_q      <= last2_d;
      last1_q      <= last1_d;
      step_q       <= step_d;
      split_q      <= split_d;
      pl_len_q     <= pl_len_d;
      active_q     <= active_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign bus.m3cnt       = cnt_q;
  assign bus.m3cntFirst1 = first1_q;
  assign bus.m3cntFirst2 = first2_q;
  assign bus.m3cntLast2  = last2_q;
  assign bus.m3cntLast1  = last1_q;
  assign bus.sgStep      = step_q;
  assign bus.plLen       = pl_len_q;
  assign bus.pwmActive1  = active_q;
  assign bus.cycleDone   = cycle_done_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Randomized bench for motoro3_step_sequencer against a period-level behavioural model.
module tb_motoro3_step_sequencer;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  motoro3_step_sequencer_if bus ();

  motoro3_step_sequencer dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #50 clk = ~clk;

  int tab [16] = '{0, 1561, 3061, 4445, 5657, 6651, 7391, 7846,
                   8000, 7846, 7391, 6651, 5657, 4445, 3061, 1561};

  // Model state: position in period, latched period, step, split, outputs.
  int m_cnt = 0, m_P = 4, m_step = 0, m_split = 0, m_pl = 0;
  bit m_act = 0, m_cd = 0, m_fresh = 1;

  always @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      m_cnt = 0; m_P = 4; m_step = 0; m_split = 0; m_pl = 0;
      m_act = 0; m_cd = 0; m_fresh = 1;
    end else if (m_cnt == m_P - 1) begin
      m_cnt   = 0;
      m_fresh = 0;
      m_P     = (int'(bus.m3r_periodLen) < 4) ? 4 : int'(bus.m3r_periodLen);
      m_act   = bus.m3r_enable;
      m_cd    = 0;
      if (m_act) begin
        if (m_split >= int'(bus.m3r_stepSplitMax)) begin
          m_split = 0;
          m_step  = (m_step + 1) % 16;
          m_cd    = (m_step == 0);
        end else begin
          m_split = m_split + 1;
        end
      end
      m_pl = m_act ? (tab[m_step] * int'(bus.m3r_amplitude)) / 256 : 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
  end

  function automatic logic [50:0] exp_vec();
    return {25'(m_cnt), (m_cnt == 0) && !m_fresh, m_cnt == 1, m_cnt == m_P - 2,
            m_cnt == m_P - 1, 4'(m_step), 16'(m_pl), m_act, m_cd};
  endfunction

  function automatic logic [50:0] obs_vec();
    return {bus.m3cnt, bus.m3cntFirst1, bus.m3cntFirst2, bus.m3cntLast2, bus.m3cntLast1,
            bus.sgStep, bus.plLen, bus.pwmActive1, bus.cycleDone};
  endfunction

  task automatic cycle();
    @(posedge clk);
  endtask

  task automatic set_inputs(input bit en, input int per, input int spl, input int amp);
    bus.m3r_enable       = en;
    bus.m3r_periodLen    = 25'(per);
    bus.m3r_stepSplitMax = 2'(spl);
    bus.m3r_amplitude    = 8'(amp);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (obs_vec() !== 51'd0) begin
      n_bad++; $display("FAIL reset_state: dut=%h required=0", obs_vec());
    end
    set_inputs(1, 10, 0, 255);
    nRst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL basic_run: dut=%h model=%h", obs_vec(), exp_vec());
      end
      if (m_cnt == 0 && (m_step == 1 || m_step == 2)) begin
        n_cmp++;
        if (bus.plLen !== ((m_step == 1) ? 16'd1554 : 16'd3049)) begin
          n_bad++; $display("FAIL pl_len_seq: dut=%0d step=%0d", bus.plLen, m_step);
        end
      end
    end
  endtask

  task automatic test_split();
    int run = 0, done_len = -1, last = -1, ival = 0;
    logic [3:0] prev;
    set_inputs(1, 6, 2, $urandom_range(1, 255));
    prev = bus.sgStep;
    for (int i = 0; i < 620; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL split_run: dut=%h model=%h", obs_vec(), exp_vec());
      end
      if (bus.cycleDone === 1'b1) run++;
      else if (run > 0 && done_len < 0) done_len = run;
      if (bus.sgStep !== prev) begin
        if (last >= 0) ival = i - last;
        last = i;
        prev = bus.sgStep;
      end
    end
    n_cmp++;
    if (done_len != 6) begin
      n_bad++; $display("FAIL cycle_done_len: dut=%0d required=6", done_len);
    end
    n_cmp++;
    if (ival != 18) begin
      n_bad++; $display("FAIL step_interval: dut=%0d required=18", ival);
    end
  endtask

  task automatic test_period_change();
    int mx [3] = '{0, 0, 0};
    int seg = 0;
    bit hit = 0;
    set_inputs(1, 10, 0, $urandom_range(0, 255));
    for (int i = 0; i < 60 && !hit; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL period_wait: dut=%h model=%h", obs_vec(), exp_vec());
      end
      hit = (m_P == 10 && m_cnt == 3);
    end
    n_cmp++;
    if (!hit) begin
      n_bad++; $display("FAIL period_wait_timeout: dut_cnt=%0d required=3", bus.m3cnt);
    end
    bus.m3r_periodLen = 25'd5;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL period_change: dut=%h model=%h", obs_vec(), exp_vec());
      end
      if (bus.m3cnt == 25'd0 && seg < 2) seg++;
      if (int'(bus.m3cnt) > mx[seg]) mx[seg] = int'(bus.m3cnt);
    end
    n_cmp++;
    if (mx[0] != 9 || mx[1] != 4) begin
      n_bad++; $display("FAIL period_lengths: dut=%0d,%0d required=9,4", mx[0], mx[1]);
    end
    bus.m3r_periodLen = 25'd2;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL period_clamp: dut=%h model=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_enable();
    bit hit = 0;
    set_inputs(1, 8, 0, 255);
    for (int i = 0; i < 300 && !hit; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL enable_wait: dut=%h model=%h", obs_vec(), exp_vec());
      end
      hit = (m_step == 7 && m_cnt == 4 && m_P == 8);
    end
    n_cmp++;
    if (!hit) begin
      n_bad++; $display("FAIL enable_wait_timeout: dut_step=%0d required=7", bus.sgStep);
    end
    bus.m3r_enable = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL disabled: dut=%h model=%h", obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({bus.sgStep, bus.plLen, bus.pwmActive1} !== {4'd7, 16'd0, 1'b0}) begin
      n_bad++; $display("FAIL hold_step: dut=%0d/%0d/%0d required=7/0/0",
                        bus.sgStep, bus.plLen, bus.pwmActive1);
    end
    bus.m3r_enable = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL reenable: dut=%h model=%h", obs_vec(), exp_vec());
      end
      hit = (bus.pwmActive1 === 1'b1);
    end
    n_cmp++;
    if ({bus.sgStep, bus.plLen} !== {4'd8, 16'd7968}) begin
      n_bad++; $display("FAIL resume_step: dut=%0d/%0d required=8/7968", bus.sgStep, bus.plLen);
    end
  endtask

  task automatic test_amplitude();
    bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL amp_wait: dut=%h model=%h", obs_vec(), exp_vec());
      end
      hit = (m_step == 7);
    end
    bus.m3r_amplitude = 8'd128;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      hit = (m_step == 8);
    end
    n_cmp++;
    if ({bus.sgStep, bus.plLen} !== {4'd8, 16'd4000}) begin
      n_bad++; $display("FAIL amp_half: dut=%0d/%0d required=8/4000", bus.sgStep, bus.plLen);
    end
    bus.m3r_amplitude = 8'd0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      hit = (m_step == 9);
    end
    n_cmp++;
    if ({bus.plLen, bus.pwmActive1} !== {16'd0, 1'b1}) begin
      n_bad++; $display("FAIL amp_zero: dut=%0d/%0d required=0/1", bus.plLen, bus.pwmActive1);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    set_inputs(1, 10, 0, $urandom_range(1, 255));
    for (int i = 0; i < 400 && !hit; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL rstmid_wait: dut=%h model=%h", obs_vec(), exp_vec());
      end
      hit = (m_step == 12 && m_cnt == 7 && m_P == 10);
    end
    n_cmp++;
    if (!hit) begin
      n_bad++; $display("FAIL rstmid_timeout: dut_step=%0d required=12", bus.sgStep);
    end
    nRst = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== 51'd0) begin
      n_bad++; $display("FAIL rstmid_clear: dut=%h required=0", obs_vec());
    end
    cycle();
    cycle();
    nRst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL rstmid_release: dut=%h model=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random: dut=%h model=%h", obs_vec(), exp_vec());
      end
      if ($urandom_range(0, 9) == 0) begin
        set_inputs($urandom_range(0, 3) != 0, $urandom_range(0, 12),
                   $urandom_range(0, 3), $urandom_range(0, 255));
      end
    end
  endtask

  initial begin
    set_inputs(0, 10, 0, 255);
    nRst = 1'b0;
    repeat (3) cycle();
    test_reset();
    test_split();
    test_period_change();
    test_enable();
    test_amplitude();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
